fp_alu_arbiter: RTL and testbench

//  - Shares one alu (FP add/mul) between two requesters; round-robin arbitration, one op in flight.
//  - alu output mux follows opcode combinationally, so opcode is held stable from issue until result capture.
//  - Sits between client blocks and alu; sole driver of alu i_vld/i_a/i_b/opcode.

---
 rtl/fp_alu_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_fp_alu_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_alu_arbiter.sv
// Round-robin arbiter that shares one FP add/mul ALU between two requesters, with one op in flight.
// Optional watchdog timeout response is enabled by defining FP_ARB_TIMEOUT_EN.
module fp_alu_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_vld,
  output logic        req0_rdy,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_op,
  input  logic        req1_vld,
  output logic        req1_rdy,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_op,
  output logic        alu_vld,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_opcode,
  input  logic [31:0] alu_res,
  input  logic        alu_res_vld,
  input  logic        alu_ovf,
  output logic        rsp_vld,
  input  logic        rsp_rdy,
  output logic        rsp_id,
  output logic [31:0] rsp_res,
  output logic        rsp_ovf,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  if (2 ** CNT_W <= TIMEOUT_CYCLES) begin : g_bad_cfg
    $error("fp_alu_arbiter: CNT_W too narrow for TIMEOUT_CYCLES");
  end

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        alu_vld_q, alu_vld_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic        alu_op_q, alu_op_d;
  logic        rsp_vld_q, rsp_vld_d;
  logic        rsp_id_q, rsp_id_d;
  logic [31:0] rsp_res_q, rsp_res_d;
  logic        rsp_ovf_q, rsp_ovf_d;
`ifdef FP_ARB_TIMEOUT_EN
  logic             rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0] wdog_q, wdog_d;
`endif

  logic grant_any;
  logic grant_id;
  logic in_idle;

  // Tie goes to the requester that did not win last; rdy is also masked while reset is asserted.
  always_comb begin
    grant_any = req0_vld | req1_vld;
    grant_id  = (req0_vld & req1_vld) ? ~last_grant_q : req1_vld;
    in_idle   = (state_q == S_IDLE);
    req0_rdy  = rst & in_idle & req0_vld & ~grant_id;
    req1_rdy  = rst & in_idle & req1_vld & grant_id;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    alu_vld_d    = alu_vld_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_vld_d    = rsp_vld_q;
    rsp_id_d     = rsp_id_q;
    rsp_res_d    = rsp_res_q;
    rsp_ovf_d    = rsp_ovf_q;
`ifdef FP_ARB_TIMEOUT_EN
    rsp_err_d    = rsp_err_q;
    wdog_d       = wdog_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          alu_a_d      = grant_id ? req1_a  : req0_a;
          alu_b_d      = grant_id ? req1_b  : req0_b;
          alu_op_d     = grant_id ? req1_op : req0_op;
          rsp_id_d     = grant_id;
          last_grant_d = grant_id;
          alu_vld_d    = 1'b1;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        alu_vld_d = 1'b0;
        state_d   = S_WAIT;
`ifdef FP_ARB_TIMEOUT_EN
        wdog_d    = '0;
`endif
      end
      S_WAIT: begin
        if (alu_res_vld) begin
          rsp_res_d = alu_res;
          rsp_ovf_d = alu_ovf;
          rsp_vld_d = 1'b1;
          state_d   = S_RESP;
`ifdef FP_ARB_TIMEOUT_EN
          rsp_err_d = 1'b0;
        end else if (wdog_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rsp_res_d = 32'h7FC0_0000;
          rsp_ovf_d = 1'b0;
          rsp_err_d = 1'b1;
          rsp_vld_d = 1'b1;
          state_d   = S_RESP;
        end else begin
          wdog_d = wdog_q + 1'b1;
`endif
        end
      end
      S_RESP: begin
        if (rsp_rdy) begin
          rsp_vld_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      alu_vld_q    <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= 1'b0;
      rsp_vld_q    <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_res_q    <= '0;
      rsp_ovf_q    <= 1'b0;
`ifdef FP_ARB_TIMEOUT_EN
      rsp_err_q    <= 1'b0;
      wdog_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      alu_vld_q    <= alu_vld_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_vld_q    <= rsp_vld_d;
      rsp_id_q     <= rsp_id_d;
      rsp_res_q    <= rsp_res_d;
      rsp_ovf_q    <= rsp_ovf_d;
`ifdef FP_ARB_TIMEOUT_EN
      rsp_err_q    <= rsp_err_d;
      wdog_q       <= wdog_d;
`endif
    end
  end

  assign alu_vld    = alu_vld_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_op_q;
  assign rsp_vld    = rsp_vld_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_res    = rsp_res_q;
  assign rsp_ovf    = rsp_ovf_q;
  assign busy       = (state_q != S_IDLE);
`ifdef FP_ARB_TIMEOUT_EN
  assign rsp_err    = rsp_err_q;
`else
  assign rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_fp_alu_arbiter.sv
// Directed self-checking bench for fp_alu_arbiter with a fixed-latency ALU stand-in.
// Timeout scenario runs only when FP_ARB_TIMEOUT_EN is defined.
module tb_fp_alu_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_vld, req0_rdy, req0_op;
  logic [31:0] req0_a, req0_b;
  logic        req1_vld, req1_rdy, req1_op;
  logic [31:0] req1_a, req1_b;
  logic        alu_vld, alu_opcode, alu_res_vld, alu_ovf;
  logic [31:0] alu_a, alu_b, alu_res;
  logic        rsp_vld, rsp_rdy, rsp_id, rsp_ovf, rsp_err, busy;
  logic [31:0] rsp_res;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_alu_arbiter #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0_vld(req0_vld), .req0_rdy(req0_rdy), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_vld(req1_vld), .req1_rdy(req1_rdy), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_vld(alu_vld), .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_res(alu_res), .alu_res_vld(alu_res_vld), .alu_ovf(alu_ovf),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_id(rsp_id), .rsp_res(rsp_res),
    .rsp_ovf(rsp_ovf), .rsp_err(rsp_err), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Hand-computed single-precision results for the vectors used here: {ovf, result}.
  function automatic logic [32:0] lut(input logic [31:0] a, input logic [31:0] b, input logic op);
    if (!op && a == 32'h3F80_0000 && b == 32'h4000_0000) return {1'b0, 32'h4040_0000};
    if (op && a == 32'h4000_0000 && b == 32'h4040_0000)  return {1'b0, 32'h40C0_0000};
    if (op && a == 32'h7F7F_FFFF && b == 32'h4000_0000)  return {1'b1, 32'h7F80_0000};
    return 33'h0;
  endfunction

  logic        alu_mute = 1'b0;
  int          pend = 0;
  logic [32:0] pend_r;

  initial begin
    alu_res_vld = 1'b0;
    alu_res     = '0;
    alu_ovf     = 1'b0;
    forever begin
      @(negedge clk);
      alu_res_vld = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0 && !alu_mute) begin
          {alu_ovf, alu_res} = pend_r;
          alu_res_vld = 1'b1;
        end
      end
      if (alu_vld) begin
        pend   = LAT;
        pend_r = lut(alu_a, alu_b, alu_opcode);
      end
    end
  end

  task automatic issue(input bit id, input logic [31:0] a, input logic [31:0] b, input logic op);
    int n = 0;
    if (id) begin req1_a = a; req1_b = b; req1_op = op; req1_vld = 1'b1; end
    else    begin req0_a = a; req0_b = b; req0_op = op; req0_vld = 1'b1; end
    #1;
    while (!(id ? req1_rdy : req0_rdy) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("grant_rdy", {31'd0, id ? req1_rdy : req0_rdy}, 32'd1);
    chk("other_rdy", {31'd0, id ? req0_rdy : req1_rdy}, 32'd0);
    @(negedge clk);
    if (id) req1_vld = 1'b0; else req0_vld = 1'b0;
    #1;
    chk("issue_vld", {31'd0, alu_vld}, 32'd1);
    chk("issue_a", alu_a, a);
    chk("issue_b", alu_b, b);
    chk("issue_op", {31'd0, alu_opcode}, {31'd0, op});
    chk("issue_busy", {31'd0, busy}, 32'd1);
    chk("issue_rdy", {30'd0, req1_rdy, req0_rdy}, 32'd0);
    @(negedge clk); #1;
    chk("vld_pulse", {31'd0, alu_vld}, 32'd0);
  endtask

  // Entered on the first WAIT cycle; checks the number of WAIT cycles seen before rsp_vld.
  task automatic get_rsp(input bit exp_id, input logic [31:0] exp_res, input logic exp_ovf,
                         input logic exp_err, input logic exp_op, input int hold, input int exp_wait);
    int n = 0;
    while (!rsp_vld && n < 50) begin
      chk("op_held", {31'd0, alu_opcode}, {31'd0, exp_op});
      @(negedge clk); #1; n++;
    end
    chk("rsp_vld", {31'd0, rsp_vld}, 32'd1);
    chk("wait_cycles", n, exp_wait);
    for (int i = 0; i <= hold; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      chk("rsp_vld_hold", {31'd0, rsp_vld}, 32'd1);
      chk("rsp_id", {31'd0, rsp_id}, {31'd0, exp_id});
      chk("rsp_res", rsp_res, exp_res);
      chk("rsp_ovf", {31'd0, rsp_ovf}, {31'd0, exp_ovf});
      chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
      chk("no_grant", {30'd0, req1_rdy, req0_rdy}, 32'd0);
    end
    rsp_rdy = 1'b1;
    @(negedge clk);
    rsp_rdy = 1'b0;
    #1;
    chk("rsp_drop", {31'd0, rsp_vld}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; rsp_rdy = 1'b0;
    req0_vld = 1'b0; req0_a = '0; req0_b = '0; req0_op = 1'b0;
    req1_vld = 1'b0; req1_a = '0; req1_b = '0; req1_op = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_alu_vld", {31'd0, alu_vld}, 32'd0);
    chk("rst_rsp_vld", {31'd0, rsp_vld}, 32'd0);
    chk("rst_rsp_res", rsp_res, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    issue(1'b0, 32'h3F80_0000, 32'h4000_0000, 1'b0);
    get_rsp(1'b0, 32'h4040_0000, 1'b0, 1'b0, 1'b0, 0, LAT);

    issue(1'b1, 32'h4000_0000, 32'h4040_0000, 1'b1);
    get_rsp(1'b1, 32'h40C0_0000, 1'b0, 1'b0, 1'b1, 0, LAT);

    req0_a = 32'h3F80_0000; req0_b = 32'h4000_0000; req0_op = 1'b0;
    req1_a = 32'h4000_0000; req1_b = 32'h4040_0000; req1_op = 1'b1;
    req0_vld = 1'b1; req1_vld = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      while (!(req0_rdy | req1_rdy) && n < 20) begin @(negedge clk); #1; n++; end
      chk("arb_any", {31'd0, req0_rdy | req1_rdy}, 32'd1);
      chk("arb_both", {31'd0, req0_rdy & req1_rdy}, 32'd0);
      chk("arb_grant", {31'd0, req1_rdy}, k % 2);
      @(negedge clk); #1;
      chk("arb_rdy_pulse", {30'd0, req1_rdy, req0_rdy}, 32'd0);
      chk("arb_op", {31'd0, alu_opcode}, k % 2);
      @(negedge clk); #1;
      get_rsp(k[0], k[0] ? 32'h40C0_0000 : 32'h4040_0000, 1'b0, 1'b0, k[0], 0, LAT);
    end
    req0_vld = 1'b0; req1_vld = 1'b0;

    issue(1'b0, 32'h7F7F_FFFF, 32'h4000_0000, 1'b1);
    req1_a = 32'h4000_0000; req1_b = 32'h4040_0000; req1_op = 1'b1; req1_vld = 1'b1;
    get_rsp(1'b0, 32'h7F80_0000, 1'b1, 1'b0, 1'b1, 5, LAT);
    chk("pending_grant", {31'd0, req1_rdy}, 32'd1);
    issue(1'b1, 32'h4000_0000, 32'h4040_0000, 1'b1);
    get_rsp(1'b1, 32'h40C0_0000, 1'b0, 1'b0, 1'b1, 0, LAT);

    issue(1'b0, 32'h3F80_0000, 32'h4000_0000, 1'b0);
    req1_a = 32'h4000_0000; req1_b = 32'h4040_0000; req1_op = 1'b1; req1_vld = 1'b1;
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_alu", {alu_vld, alu_opcode, 30'd0}, 32'd0);
    chk("mid_rst_a", alu_a | alu_b, 32'd0);
    chk("mid_rst_rsp", {rsp_vld, rsp_id, rsp_ovf, rsp_err, 28'd0}, 32'd0);
    chk("mid_rst_res", rsp_res, 32'd0);
    chk("mid_rst_rdy", {30'd0, req1_rdy, req0_rdy}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post_rst_rsp", {31'd0, rsp_vld}, 32'd0);
    issue(1'b1, 32'h4000_0000, 32'h4040_0000, 1'b1);
    get_rsp(1'b1, 32'h40C0_0000, 1'b0, 1'b0, 1'b1, 0, LAT);

`ifdef FP_ARB_TIMEOUT_EN
    alu_mute = 1'b1;
    issue(1'b0, 32'h3F80_0000, 32'h4000_0000, 1'b0);
    get_rsp(1'b0, 32'h7FC0_0000, 1'b0, 1'b1, 1'b0, 0, 8);
    alu_mute = 1'b0;
    issue(1'b1, 32'h4000_0000, 32'h4040_0000, 1'b1);
    get_rsp(1'b1, 32'h40C0_0000, 1'b0, 1'b0, 1'b1, 0, LAT);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
